// File: rtl/des_perm_pipe.sv
// rtl/des_perm_pipe.sv - pipelined DES IP / IP^-1 bit-permutation engine
//
// Applies the DES initial permutation (in_mode=0) or final permutation
// (in_mode=1) to LANES independent 64-bit blocks per beat, then carries the
// result through PIPE_STAGES valid/ready register stages.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush               synchronous clear of all stage valids
//   in_valid/in_ready   input handshake (in_ready combinational from out_ready)
//   in_mode, in_data    beat mode and LANES*64 data (lane 0 in top 64 bits,
//                       DES bit 1 is the MSB of each lane)
//   out_valid/out_ready output handshake
//   out_mode, out_data  permuted beat and the mode it was permuted with
//   beat_cnt            count of output transfers, wraps modulo 2^CNT_W
//   in_tag, out_tag     optional side-band tag, present when DES_PERM_TAG_EN
//                       is defined (width TAG_W)
module des_perm_pipe #(
   parameter int LANES       = 1,
   parameter int PIPE_STAGES = 2,
   parameter int CNT_W       = 32
`ifdef DES_PERM_TAG_EN
   ,
   parameter int TAG_W       = 8
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_mode,
   input  logic [64*LANES-1:0]   in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [64*LANES-1:0]   out_data,
   output logic                  out_mode,
   output logic [CNT_W-1:0]      beat_cnt
`ifdef DES_PERM_TAG_EN
   ,
   input  logic [TAG_W-1:0]      in_tag,
   output logic [TAG_W-1:0]      out_tag
`endif
);

   localparam int DW   = 64*LANES;
   localparam int LAST = PIPE_STAGES-1;

   // Source bit (1-based, DES numbering) for IP output bit k. Each row of the
   // IP table starts at 58,60,62,64,57,59,61,63 and steps down by 8.
   function automatic int ip_src(input int k);
      int r;
      int c;
      int base;
      r = (k-1) / 8;
      c = (k-1) % 8;
      if (r < 4) base = 58 + 2*r;
      else       base = 57 + 2*(r-4);
      return base - 8*c;
   endfunction

   // ---------------------------------------------------------------------
   // Permutation network. IP^-1 is built as the inverse wiring of IP, so
   // the two are exact inverses by construction.
   // ---------------------------------------------------------------------
   logic [DW-1:0] perm_data;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [63:0] lin;
      logic [63:0] ip_o;
      logic [63:0] fp_o;

      assign lin = in_data[DW-1-64*l -: 64];

      for (genvar k = 1; k <= 64; k++) begin : g_bit
         localparam int S = ip_src(k);
         assign ip_o[64-k] = lin[64-S];
         assign fp_o[64-S] = lin[64-k];
      end

      assign perm_data[DW-1-64*l -: 64] = in_mode ? fp_o : ip_o;
   end

   // ---------------------------------------------------------------------
   // Pipeline stages
   // ---------------------------------------------------------------------
   logic [PIPE_STAGES-1:0] v;
   logic [PIPE_STAGES-1:0] load;
   logic [DW-1:0]          d [PIPE_STAGES];
   logic                   m [PIPE_STAGES];
   logic [CNT_W-1:0]       cnt;
`ifdef DES_PERM_TAG_EN
   logic [TAG_W-1:0]       t [PIPE_STAGES];
`endif

   // A stage may load when it is empty or its content moves on this cycle;
   // evaluated from the output backwards so empty stages absorb bubbles.
   always_comb begin
      logic taken;
      load  = '0;
      taken = out_ready;
      for (int i = LAST; i >= 0; i--) begin
         load[i] = !v[i] || taken;
         taken   = load[i];
      end
   end

   assign in_ready = load[0] && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v   <= '0;
         cnt <= '0;
         for (int i = 0; i < PIPE_STAGES; i++) begin
            d[i] <= '0;
            m[i] <= 1'b0;
`ifdef DES_PERM_TAG_EN
            t[i] <= '0;
`endif
         end
      end else begin
         // An output transfer in the flush cycle still counts.
         if (v[LAST] && out_ready) cnt <= cnt + CNT_W'(1);

         if (flush) begin
            v <= '0;
         end else begin
            if (load[0]) v[0] <= in_valid;
            for (int i = 1; i < PIPE_STAGES; i++) begin
               if (load[i]) v[i] <= v[i-1];
            end
         end

         // Data only moves with a valid beat so held outputs stay stable.
         if (load[0] && in_valid && !flush) begin
            d[0] <= perm_data;
            m[0] <= in_mode;
`ifdef DES_PERM_TAG_EN
            t[0] <= in_tag;
`endif
         end
         for (int i = 1; i < PIPE_STAGES; i++) begin
            if (load[i] && v[i-1] && !flush) begin
               d[i] <= d[i-1];
               m[i] <= m[i-1];
`ifdef DES_PERM_TAG_EN
               t[i] <= t[i-1];
`endif
            end
         end
      end
   end

   assign out_valid = v[LAST];
   assign out_data  = d[LAST];
   assign out_mode  = m[LAST];
   assign beat_cnt  = cnt;
`ifdef DES_PERM_TAG_EN
   assign out_tag   = t[LAST];
`endif

endmodule

// File: tb/tb_des_perm_pipe.sv
// tb/tb_des_perm_pipe.sv - directed self-checking bench for des_perm_pipe
module tb_des_perm_pipe;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_mode = 1'b0;
   logic          out_ready = 1'b1;
   logic [63:0]   in_data = '0;
   logic [127:0]  in_data2;
   logic          in_ready, out_valid, out_mode;
   logic [63:0]   out_data;
   logic [31:0]   beat_cnt;
   logic          in_ready2, out_valid2, out_mode2;
   logic [127:0]  out_data2;
   logic [31:0]   beat_cnt2;
`ifdef DES_PERM_TAG_EN
   logic [7:0]    in_tag = '0;
   logic [7:0]    out_tag, out_tag2;
`endif

   int passed = 0;
   int failed = 0;
   int total  = 0;
   int nxt, rcv;
   logic          held_valid;
   logic [63:0]   held_data;
   logic          seen;

   int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                     62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                     57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                     38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                     36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                     34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   logic [63:0] P [6] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                          64'h0000000000000001, 64'h8000000000000000,
                          64'hDEADBEEFCAFEF00D, 64'h5555AAAA3333CCCC};

   assign in_data2 = {in_data, 64'h0};

   des_perm_pipe #(.LANES(1), .PIPE_STAGES(2), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_mode(out_mode), .beat_cnt(beat_cnt)
`ifdef DES_PERM_TAG_EN
      , .in_tag(in_tag), .out_tag(out_tag)
`endif
   );

   des_perm_pipe #(.LANES(2), .PIPE_STAGES(2), .CNT_W(32)) dut2 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready2), .in_mode(in_mode), .in_data(in_data2),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .out_mode(out_mode2), .beat_cnt(beat_cnt2)
`ifdef DES_PERM_TAG_EN
      , .in_tag(in_tag), .out_tag(out_tag2)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [63:0] ref_perm(input logic [63:0] x, input logic md);
      logic [63:0] r;
      int src;
      r = '0;
      for (int k = 0; k < 64; k++) begin
         src = md ? FP_T[k] : IP_T[k];
         r[63-k] = x[64-src];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] dat, input logic md);
      in_valid = 1'b1;
      in_data  = dat;
      in_mode  = md;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_beat_cnt", beat_cnt, 0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);

      // single beat, IP, latency 2
      step();
      send(64'h0123456789ABCDEF, 1'b0);
      chk("lat_not_yet", out_valid, 0);
      step();
      chk("ip_valid", out_valid, 1);
      chk("ip_data", out_data, 64'hCC00CCFFF0AAF0AA);
      chk("ip_mode", out_mode, 0);
      chk("lanes2_data", out_data2, {64'hCC00CCFFF0AAF0AA, 64'h0});
      step();
      chk("cnt_after_a", beat_cnt, 1);
      chk("empty_after_a", out_valid, 0);

      // back-to-back beats, mixed modes and single-bit vectors
      send(64'hCC00CCFFF0AAF0AA, 1'b1);
      send(64'h0000000000000001, 1'b0);
      chk("fp_data", out_data, 64'h0123456789ABCDEF);
      chk("fp_mode", out_mode, 1);
      send(64'h8000000000000000, 1'b1);
      chk("ip_bit64", out_data, 64'h0000008000000000);
      step();
      chk("fp_bit1", out_data, 64'h0000000000000040);
      chk("fp_bit1_valid", out_valid, 1);
      step();
      chk("cnt_after_bcd", beat_cnt, 4);

      // backpressure: out_ready low for 4 cycles while streaming 6 beats
      nxt = 0;
      rcv = 0;
      held_valid = 1'b0;
      held_data = '0;
      for (int c = 0; c < 30 && rcv < 6; c++) begin
         out_ready = (c >= 4);
         in_valid  = (nxt < 6);
         in_data   = (nxt < 6) ? P[nxt] : 64'h0;
         in_mode   = nxt[0];
         #3;
         if (held_valid) chk("bp_hold", out_data, held_data);
         if (c == 1) chk("bp_ready_c1", in_ready, 1);
         if (c == 2) chk("bp_ready_full", in_ready, 0);
         if (c == 4) chk("bp_ready_passthru", in_ready, 1);
         held_valid = out_valid && !out_ready;
         held_data  = out_data;
         if (out_valid && out_ready) begin
            chk($sformatf("bp_beat%0d", rcv), out_data, ref_perm(P[rcv], rcv[0]));
            chk($sformatf("bp_mode%0d", rcv), out_mode, rcv[0]);
            rcv++;
         end
         if (in_valid && in_ready) nxt++;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_all_received", rcv, 6);
      chk("bp_cnt", beat_cnt, 10);

      // flush with two beats in flight and an offered input
      out_ready = 1'b0;
      send(64'h1111111111111111, 1'b0);
      send(64'h2222222222222222, 1'b0);
      chk("pre_flush_valid", out_valid, 1);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 64'h3333333333333333;
      #1;
      chk("flush_in_ready", in_ready, 0);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_valid", out_valid, 0);
      chk("flush_cnt", beat_cnt, 10);
      out_ready = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      chk("flush_no_ghost", seen, 0);

      // flush while an output transfer completes: that transfer counts
      send(64'h4444444444444444, 1'b0);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_xfer_cnt", beat_cnt, 11);
      chk("flush_xfer_valid", out_valid, 0);

      // asynchronous reset between edges
      out_ready = 1'b0;
      send(64'h5555555555555555, 1'b0);
      send(64'h6666666666666666, 1'b1);
      chk("pre_rst_valid", out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_cnt", beat_cnt, 0);
      chk("async_rst_data", out_data, 0);
      #2;
      rst = 1'b0;
      #1;
      chk("post_rst_ready", in_ready, 1);
      out_ready = 1'b1;
      step();
      send(64'h0123456789ABCDEF, 1'b0);
      chk("post_rst_lat", out_valid, 0);
      step();
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_data", out_data, 64'hCC00CCFFF0AAF0AA);
      step();
      chk("post_rst_cnt", beat_cnt, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/des_perm_pipe.md
Name: des_perm_pipe

Overview:
- Pipelined, parametrised DES bit-permutation engine, placed between the block-input/output buffers and the 16-round core.
- Applies either the initial permutation (IP) or the final permutation (IP^-1), selected per beat, to LANES independent 64-bit blocks per beat.
- Valid/ready handshake, PIPE_STAGES register stages with per-stage backpressure, synchronous flush and a processed-block counter.

Parameters:
- LANES, 1, number of 64-bit blocks per beat (1..8).
- PIPE_STAGES, 2, register stages between input and output (1..4); sets latency.
- CNT_W, 32, width of the processed-beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: asynchronous, active-high.
- flush  input  1  synchronous pipeline clear.
- in_valid  input  1  input beat valid.
- in_ready  output  1  engine can accept a beat this cycle.
- in_mode  input  1  0 = IP, 1 = IP^-1; sampled with the beat.
- in_data  input  64*LANES  lane 0 occupies the top 64 bits; within a lane, DES bit 1 is the MSB.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  64*LANES  permuted beat, same lane and bit order as in_data.
- out_mode  output  1  mode the beat was permuted with.
- beat_cnt  output  CNT_W  number of beats accepted at the output.

Behaviour:
- Permutation logic sits in front of stage 0 and is combinational on in_data/in_mode. Stages 1..PIPE_STAGES-1 are pure delay.
- IP: out bit k = in bit IP[k], with IP = 58 50 42 34 26 18 10 2, 60 52 44 36 28 20 12 4, 62 54 46 38 30 22 14 6, 64 56 48 40 32 24 16 8, 57 49 41 33 25 17 9 1, 59 51 43 35 27 19 11 3, 61 53 45 37 29 21 13 5, 63 55 47 39 31 23 15 7.
- IP^-1: out bit k = in bit FP[k], with FP = 40 8 48 16 56 24 64 32, 39 7 47 15 55 23 63 31, 38 6 46 14 54 22 62 30, 37 5 45 13 53 21 61 29, 36 4 44 12 52 20 60 28, 35 3 43 11 51 19 59 27, 34 2 42 10 50 18 58 26, 33 1 41 9 49 17 57 25.
- All lanes of a beat use the same mode. Lanes are fully independent; there is no cross-lane bit movement.
- Each stage i holds v[i], data and mode.
  - Stage i loads when v[i]==0 or stage i+1 (or the output, for the last stage) takes its content.
  - The last stage's content is taken when out_ready==1.
  - in_ready = stage-0 load condition. This is combinational from out_ready through the chain; there is no skid.
- Bubbles collapse: an empty stage accepts even while later stages stall.
- Handshake:
  - A beat transfers when in_valid && in_ready.
  - With no stalls, latency from input transfer to out_valid is exactly PIPE_STAGES cycles, at 1 beat/cycle throughput.
  - out_data, out_mode and out_valid hold stable while out_valid && !out_ready.
- beat_cnt increments by 1 on each out_valid && out_ready and wraps modulo 2^CNT_W.
- flush: on the next edge all v[i] clear.
  - The input beat offered in the flush cycle is dropped, and in_ready is forced to 0 during flush.
  - beat_cnt counts an output transfer that completes in the flush cycle, and is not otherwise cleared.
  - Data registers are not cleared.
- Reset, asynchronous, including mid-operation:
  - All v[i] = 0, out_valid = 0, data = 0, out_mode = 0, beat_cnt = 0.
  - in_ready reads 1 once rst deasserts.
  - In-flight beats are lost.
- Simultaneous events: a full pipeline with out_ready==1 accepts a new input in the same cycle; flush has priority over both transfers except the output count above.

Optional Feature:
- DES_PERM_TAG_EN, with parameter TAG_W default 8.
- Defined: adds ports in_tag (input, TAG_W) and out_tag (output, TAG_W). The tag travels with its beat through every stage with identical stall, flush and reset behaviour, and resets to 0.
- Undefined: no tag ports and no tag registers; behaviour is otherwise identical.

Test Plan:
- LANES=1, PIPE_STAGES=2: in_data=0x0123456789ABCDEF, mode 0 -> out_valid 2 cycles later, out_data=0xCC00CCFFF0AAF0AA, out_mode=0.
- Mode 1 with in_data=0xCC00CCFFF0AAF0AA -> 0x0123456789ABCDEF. Also single-bit checks: mode 0 with 0x0000000000000001 -> 0x0000008000000000; mode 1 with 0x8000000000000000 -> 0x0000000000000040.
- LANES=2: lane0 = 0x0123456789ABCDEF (mode 0), lane1 = 0 -> out = {0xCC00CCFFF0AAF0AA, 0x0}, confirming no lane crosstalk.
- Backpressure: stream 6 beats with out_ready held low 4 cycles -> in_ready drops after PIPE_STAGES beats are buffered, out_data holds, all 6 beats emerge in order, beat_cnt=6.
- Flush with 2 beats in flight and in_valid=1 -> next cycle out_valid=0 and no dropped beat ever appears; beat_cnt unchanged unless an output transfer occurred in the flush cycle.
- Assert rst asynchronously mid-stream, between clock edges -> out_valid and beat_cnt go to 0 immediately; after release the first new beat appears with the correct permutation and latency.
